// File: rtl/pad_pkg.sv
// Shared types and helpers for the pad-interface memory responder.
package pad_pkg;

  typedef enum logic [1:0] {
    PAD_SIZE_BYTE = 2'b00,
    PAD_SIZE_HALF = 2'b01,
    PAD_SIZE_WORD = 2'b11
  } pad_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDRESSED,
    ST_WAIT,
    ST_READ_RETURN
  } pad_state_t;

  localparam int unsigned PAD_WAIT_WIDTH = 4;

  // The reserved encoding 2'b10 behaves as a word access.
  function automatic pad_size_t pad_decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return PAD_SIZE_BYTE;
      2'b01:   return PAD_SIZE_HALF;
      default: return PAD_SIZE_WORD;
    endcase
  endfunction

  function automatic logic pad_is_aligned(input pad_size_t size, input logic [1:0] addr_lo);
    case (size)
      PAD_SIZE_BYTE: return 1'b1;
      PAD_SIZE_HALF: return (addr_lo[0] == 1'b0);
      default:       return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/pad_lane_aligner.sv
// Byte-lane steering between the pad bus and the word-organised SRAM port.
module pad_lane_aligner
  import pad_pkg::*;
(
  input  pad_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] write_data,
  input  logic [31:0] read_word,
  output logic [31:0] lane_write_data,
  output logic [3:0]  byte_enable,
  output logic [31:0] read_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted         = read_word >> {addr_lo, 3'b000};
    lane_write_data = write_data;
    byte_enable     = 4'b1111;
    read_data       = shifted;
    case (size)
      PAD_SIZE_BYTE: begin
        lane_write_data = {4{write_data[7:0]}};
        byte_enable     = 4'b0001 << addr_lo;
        read_data       = {24'h000000, shifted[7:0]};
      end
      PAD_SIZE_HALF: begin
        lane_write_data = {2{write_data[15:0]}};
        byte_enable     = 4'b0011 << {addr_lo[1], 1'b0};
        read_data       = {16'h0000, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pad_responder.sv
// Memory-side responder: latches a byte address, then serves one sized read or
// write against a synchronous SRAM with optional wait states.
module pad_responder
  import pad_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned WAIT_STATES   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              pad_ad,
  input  logic                     pad_write_address,
  input  logic                     pad_read,
  input  logic                     pad_write,
  input  logic [1:0]               pad_data_size,
  output logic [31:0]              pad_data_out,
  output logic                     pad_ready,
  output logic                     pad_error,
  output logic [ADDRESS_WIDTH-3:0] mem_address,
  output logic [31:0]              mem_write_data,
  output logic [3:0]               mem_byte_enable,
  output logic                     mem_write,
  output logic                     mem_read,
  input  logic [31:0]              mem_read_data
);

  localparam logic [PAD_WAIT_WIDTH-1:0] WAIT_LOAD = PAD_WAIT_WIDTH'(WAIT_STATES);

  pad_state_t                state, state_n;
  logic [PAD_WAIT_WIDTH-1:0] count;
  logic [ADDRESS_WIDTH-1:0]  addr_q, pend_addr, op_addr;
  logic                      pend_valid;
  pad_size_t                 req_size, op_size, al_size;
  logic [1:0]                al_lo;
  logic                      op_write;
  logic [31:0]               wdata_q, data_out_q, lane_wdata, lane_rdata;
  logic [3:0]                be_q, lane_be;
  logic                      error_q;

  logic access_req, accept, finish, err_n;
  logic addr_load, addr_from_pend, pend_set, pend_clear;

  // One aligner serves both directions: the read word is only steered in READ_RETURN.
  assign al_size = (state == ST_READ_RETURN) ? op_size       : req_size;
  assign al_lo   = (state == ST_READ_RETURN) ? op_addr[1:0]  : addr_q[1:0];

  pad_lane_aligner u_lane_aligner (
    .size            (al_size),
    .addr_lo         (al_lo),
    .write_data      (pad_ad),
    .read_word       (mem_read_data),
    .lane_write_data (lane_wdata),
    .byte_enable     (lane_be),
    .read_data       (lane_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    req_size       = pad_decode_size(pad_data_size);
    access_req     = pad_read | pad_write;
    state_n        = state;
    pad_ready      = 1'b0;
    accept         = 1'b0;
    finish         = 1'b0;
    err_n          = 1'b0;
    addr_load      = 1'b0;
    addr_from_pend = 1'b0;
    pend_set       = 1'b0;
    pend_clear     = 1'b0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;

    case (state)
      ST_IDLE: begin
        pad_ready = 1'b1;
        err_n     = access_req;
        if (pad_write_address) begin
          addr_load = 1'b1;
          state_n   = ST_ADDRESSED;
        end
      end
      ST_ADDRESSED: begin
        pad_ready = 1'b1;
        if (pad_read && pad_write) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (access_req) begin
          if (pad_is_aligned(req_size, addr_q[1:0])) begin
            accept  = 1'b1;
            state_n = ST_WAIT;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
        if (pad_write_address) begin
          if (accept) begin
            pend_set = 1'b1;
          end else begin
            addr_load = 1'b1;
            state_n   = ST_ADDRESSED;
          end
        end
      end
      // Zero wait states still pass through WAIT with the counter at zero,
      // which is exactly the strobe cycle.
      ST_WAIT: begin
        err_n = access_req;
        if (count == '0) begin
          mem_write = op_write;
          mem_read  = !op_write;
          if (op_write) finish  = 1'b1;
          else          state_n = ST_READ_RETURN;
        end
      end
      ST_READ_RETURN: begin
        err_n  = access_req;
        finish = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (finish) begin
      pend_clear = 1'b1;
      if (pad_write_address) begin
        addr_load = 1'b1;
        state_n   = ST_ADDRESSED;
      end else if (pend_valid) begin
        addr_from_pend = 1'b1;
        state_n        = ST_ADDRESSED;
      end else begin
        state_n = ST_IDLE;
      end
    end else if ((state == ST_WAIT || state == ST_READ_RETURN) && pad_write_address) begin
      pend_set = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      addr_q     <= '0;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      op_addr    <= '0;
      op_size    <= PAD_SIZE_BYTE;
      op_write   <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      data_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= err_n;

      if (addr_load)           addr_q <= pad_ad[ADDRESS_WIDTH-1:0];
      else if (addr_from_pend) addr_q <= pend_addr;

      if (pend_set) begin
        pend_addr  <= pad_ad[ADDRESS_WIDTH-1:0];
        pend_valid <= 1'b1;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end

      if (accept) begin
        op_addr  <= addr_q;
        op_size  <= req_size;
        op_write <= pad_write;
        wdata_q  <= lane_wdata;
        be_q     <= lane_be;
        count    <= WAIT_LOAD;
      end else if (state == ST_WAIT && count != '0) begin
        count <= count - 1'b1;
      end

      if (state == ST_READ_RETURN) data_out_q <= lane_rdata;
    end
  end

  assign pad_data_out    = data_out_q;
  assign pad_error       = error_q;
  assign mem_address     = op_addr[ADDRESS_WIDTH-1:2];
  assign mem_write_data  = wdata_q;
  assign mem_byte_enable = be_q;

endmodule

// File: tb/tb_pad_responder.sv
// Bench for pad_responder: a zero-wait and a three-wait instance against a byte-level memory model.
`timescale 1ns/1ps
module tb_pad_responder;

  logic        clock = 1'b0;
  logic        rst  [2];
  logic [31:0] ad   [2];
  logic        wa   [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [1:0]  sz   [2];
  logic [31:0] dout [2];
  logic        rdy  [2];
  logic        err  [2];
  logic [13:0] maddr[2];
  logic [31:0] mwd  [2];
  logic [3:0]  mbe  [2];
  logic        mw   [2];
  logic        mr   [2];
  logic [31:0] mrd  [2];

  logic [31:0] sram [2][64];
  bit          sram_loaded = 1'b0;
  logic [7:0]  model_mem [2][256];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pad_responder #(.ADDRESS_WIDTH(16), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(rst[0]), .pad_ad(ad[0]), .pad_write_address(wa[0]),
    .pad_read(rd[0]), .pad_write(wr[0]), .pad_data_size(sz[0]),
    .pad_data_out(dout[0]), .pad_ready(rdy[0]), .pad_error(err[0]),
    .mem_address(maddr[0]), .mem_write_data(mwd[0]), .mem_byte_enable(mbe[0]),
    .mem_write(mw[0]), .mem_read(mr[0]), .mem_read_data(mrd[0]));

  pad_responder #(.ADDRESS_WIDTH(16), .WAIT_STATES(3)) u_dut3 (
    .clock(clock), .reset(rst[1]), .pad_ad(ad[1]), .pad_write_address(wa[1]),
    .pad_read(rd[1]), .pad_write(wr[1]), .pad_data_size(sz[1]),
    .pad_data_out(dout[1]), .pad_ready(rdy[1]), .pad_error(err[1]),
    .mem_address(maddr[1]), .mem_write_data(mwd[1]), .mem_byte_enable(mbe[1]),
    .mem_write(mw[1]), .mem_read(mr[1]), .mem_read_data(mrd[1]));

  function automatic logic [31:0] init_word(input int k, input int w);
    return (32'h9E37_79B9 * 32'(w + 1)) ^ 32'(k * 32'h0101_0101);
  endfunction

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int size_bytes(input logic [1:0] raw);
    return (raw == 2'b00) ? 1 : (raw == 2'b01) ? 2 : 4;
  endfunction

  // Synchronous SRAM seen by each instance: read data one cycle after the strobe.
  always @(posedge clock) begin
    if (!sram_loaded) begin
      for (int k = 0; k < 2; k++)
        for (int w = 0; w < 64; w++) sram[k][w] <= init_word(k, w);
      sram_loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mr[k]) mrd[k] <= sram[k][maddr[k][5:0]];
        if (mw[k])
          for (int b = 0; b < 4; b++)
            if (mbe[k][b]) sram[k][maddr[k][5:0]][8*b +: 8] <= mwd[k][8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_write(input int i, input logic [15:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) model_mem[i][(int'(a) + k) % 256] = d[8*k +: 8];
  endtask

  // A strobe in IDLE has no address to act on and must be rejected.
  task automatic probe_idle(input int i);
    rd[i] = 1'b1; sz[i] = 2'b00;
    tick();
    rd[i] = 1'b0;
    check("idle_probe_err", 32'(err[i]), 32'd1);
    check("idle_probe_no_read", 32'(mr[i]), 32'd0);
    tick();
    check("idle_probe_err_clear", 32'(err[i]), 32'd0);
  endtask

  task automatic run_access(input int i, input bit send_addr, input bit write, input logic [1:0] sraw,
                            input logic [15:0] a, input logic [31:0] d,
                            input bit with_pending, input logic [15:0] pa);
    int n, ws, strobe_at, back_at;
    bit aligned;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0] exp_be;
    n = size_bytes(sraw);
    ws = wait_of(i);
    aligned = ((int'(a) % n) == 0);
    if (send_addr) begin
      ad[i] = {16'($urandom), a};
      wa[i] = 1'b1;
      tick();
      wa[i] = 1'b0;
      check("addressed_ready", 32'(rdy[i]), 32'd1);
    end
    exp_be = '0; exp_rd = '0; exp_wd = '0;
    for (int k = 0; k < n; k++) begin
      exp_be[(int'(a) + k) % 4] = 1'b1;
      exp_rd[8*k +: 8] = model_mem[i][(int'(a) + k) % 256];
    end
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = d[8*(j % n) +: 8];

    wr[i] = write; rd[i] = !write; sz[i] = sraw;
    ad[i] = write ? d : (with_pending ? {16'($urandom), pa} : $urandom);
    wa[i] = with_pending;
    tick();
    wr[i] = 1'b0; rd[i] = 1'b0; wa[i] = 1'b0;

    if (!aligned) begin
      check("misaligned_err", 32'(err[i]), 32'd1);
      check("misaligned_no_strobe", 32'(mw[i] | mr[i]), 32'd0);
      check("misaligned_ready", 32'(rdy[i]), 32'd1);
      tick();
      check("misaligned_err_one_cycle", 32'(err[i]), 32'd0);
      probe_idle(i);
      return;
    end

    strobe_at = 0; back_at = 0;
    for (int c = 1; c <= 12; c++) begin
      if ((mw[i] | mr[i]) && strobe_at == 0) begin
        strobe_at = c;
        check("strobe_dir", 32'(mw[i]), 32'(write));
        check("strobe_addr", 32'(maddr[i]), 32'(a >> 2));
        if (write) begin
          check("write_be", 32'(mbe[i]), 32'(exp_be));
          check("write_data", mwd[i], exp_wd);
          model_write(i, a, n, d);
        end
      end
      if (rdy[i]) begin
        back_at = c;
        break;
      end
      tick();
    end
    check("strobe_latency", strobe_at, 1 + ws);
    check("ready_return", back_at, (write ? 2 : 3) + ws);
    if (!write) check("read_data", dout[i], exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; ad[k] = '0; wa[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; sz[k] = 2'b00;
      for (int w = 0; w < 64; w++) begin
        logic [31:0] iw;
        iw = init_word(k, w);
        for (int b = 0; b < 4; b++) model_mem[k][4*w + b] = iw[8*b +: 8];
      end
    end
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      check("reset_ready", 32'(rdy[k]), 32'd1);
      check("reset_dout", dout[k], 32'd0);
      check("reset_err", 32'(err[k]), 32'd0);
      check("reset_mem_strobes", 32'(mw[k] | mr[k]), 32'd0);
      check("reset_mem_addr", 32'(maddr[k]), 32'd0);
      check("reset_mem_be", 32'(mbe[k]), 32'd0);
      check("reset_mem_wdata", mwd[k], 32'd0);
    end
    rst[0] = 1'b1; rst[1] = 1'b1;
    check("release_no_strobe", 32'(mw[0] | mr[0] | mw[1] | mr[1]), 32'd0);
    tick();

    // Half write at 0x0006.
    run_access(0, 1, 1, 2'b01, 16'h0006, 32'hA1B2_C3D4, 0, 16'h0);
    check("half_wr_addr", 32'(maddr[0]), 32'h0001);
    check("half_wr_be", 32'(mbe[0]), 32'b1100);
    check("half_wr_data", mwd[0], 32'hC3D4_C3D4);

    // Word 0x11223344 at 0x0008, then byte read at 0x000B.
    run_access(0, 1, 1, 2'b11, 16'h0008, 32'h1122_3344, 0, 16'h0);
    run_access(0, 1, 0, 2'b00, 16'h000B, 32'h0, 0, 16'h0);
    check("byte_read_0B", dout[0], 32'h0000_0011);
    run_access(0, 1, 0, 2'b01, 16'h000A, 32'h0, 0, 16'h0);
    check("half_read_0A", dout[0], 32'h0000_1122);
    run_access(0, 1, 0, 2'b10, 16'h0008, 32'h0, 0, 16'h0);
    check("size10_word_read", dout[0], 32'h1122_3344);

    // Three wait states.
    run_access(1, 1, 0, 2'b11, 16'h0010, 32'h0, 0, 16'h0);
    run_access(1, 1, 1, 2'b11, 16'h0014, 32'h0BAD_F00D, 0, 16'h0);

    // Protocol errors.
    run_access(0, 1, 1, 2'b11, 16'h0002, 32'hDEAD_BEEF, 0, 16'h0);
    ad[0] = 32'h0000_0004; wa[0] = 1'b1; tick(); wa[0] = 1'b0;
    rd[0] = 1'b1; wr[0] = 1'b1; sz[0] = 2'b11;
    tick();
    rd[0] = 1'b0; wr[0] = 1'b0;
    check("rdwr_err", 32'(err[0]), 32'd1);
    check("rdwr_no_strobe", 32'(mw[0] | mr[0]), 32'd0);
    tick();
    check("rdwr_err_one_cycle", 32'(err[0]), 32'd0);
    probe_idle(0);
    rd[0] = 1'b1;
    tick();
    check("b2b_err_first", 32'(err[0]), 32'd1);
    tick();
    check("b2b_err_second", 32'(err[0]), 32'd1);
    rd[0] = 1'b0;
    tick();
    check("b2b_err_end", 32'(err[0]), 32'd0);

    // Address strobe alongside an accepted read becomes the next address.
    run_access(0, 1, 0, 2'b11, 16'h0004, 32'h0, 1, 16'h0020);
    check("pending_addressed", 32'(rdy[0]), 32'd1);
    run_access(0, 0, 0, 2'b11, 16'h0020, 32'h0, 0, 16'h0);
    check("pending_mem_addr", 32'(maddr[0]), 32'h0008);

    // Busy strobes on the wait-state instance: read dropped, two address strobes.
    ad[1] = 32'h0000_0024; wa[1] = 1'b1; tick(); wa[1] = 1'b0;
    wr[1] = 1'b1; sz[1] = 2'b11; ad[1] = 32'hCAFE_F00D;
    tick();
    wr[1] = 1'b0; rd[1] = 1'b1;
    tick();
    rd[1] = 1'b0;
    check("busy_read_err", 32'(err[1]), 32'd1);
    check("busy_ready_low", 32'(rdy[1]), 32'd0);
    wa[1] = 1'b1; ad[1] = 32'h0000_0030;
    tick();
    check("busy_err_one_cycle", 32'(err[1]), 32'd0);
    ad[1] = 32'h0000_0034;
    tick();
    wa[1] = 1'b0;
    check("busy_write_strobe", 32'(mw[1]), 32'd1);
    check("busy_write_addr", 32'(maddr[1]), 32'h0009);
    model_write(1, 16'h0024, 4, 32'hCAFE_F00D);
    tick();
    check("busy_then_addressed", 32'(rdy[1]), 32'd1);
    run_access(1, 0, 0, 2'b11, 16'h0034, 32'h0, 0, 16'h0);
    check("second_pending_wins", 32'(maddr[1]), 32'h000D);
    run_access(1, 1, 0, 2'b11, 16'h0024, 32'h0, 0, 16'h0);
    check("busy_write_landed", dout[1], 32'hCAFE_F00D);

    // Reset during WAIT of a write aborts it.
    ad[1] = 32'h0000_0040; wa[1] = 1'b1; tick(); wa[1] = 1'b0;
    wr[1] = 1'b1; sz[1] = 2'b11; ad[1] = 32'h5555_AAAA;
    tick();
    wr[1] = 1'b0;
    tick();
    rst[1] = 1'b0;
    #1;
    check("abort_ready", 32'(rdy[1]), 32'd1);
    check("abort_dout", dout[1], 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen |= mw[1] | mr[1];
      tick();
    end
    rst[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      seen |= mw[1] | mr[1];
      tick();
    end
    check("abort_no_strobe", 32'(seen), 32'd0);
    probe_idle(1);
    run_access(1, 1, 0, 2'b11, 16'h0040, 32'h0, 0, 16'h0);

    // Random accesses, mostly aligned.
    for (int t = 0; t < 60; t++) begin
      int i, n;
      logic [1:0] sraw;
      logic [15:0] a;
      i = t % 2;
      sraw = 2'($urandom_range(0, 3));
      n = size_bytes(sraw);
      a = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) a = a & ~16'(n - 1);
      run_access(i, 1, 1'($urandom_range(0, 1)), sraw, a, $urandom, 0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
